// File: rtl/axi_write_beat_sequencer.sv
// rtl/axi_write_beat_sequencer.sv - splits one merged AW/W burst into per-beat cache write requests and returns B
// Optional feature macro: WLAST_CHECK_EN (flags a WLAST that disagrees with the beat count as SLVERR)
module axi_write_beat_sequencer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   in_awaddr,
    input  logic [ID_WIDTH-1:0]     in_awid,
    input  logic [1:0]              in_awburst,
    input  logic [2:0]              in_awsize,
    input  logic [7:0]              in_awlen,
    input  logic                    in_awvalid,
    output logic                    in_awready,
    input  logic [DATA_WIDTH-1:0]   in_wdata,
    input  logic [DATA_WIDTH/8-1:0] in_wstrb,
    input  logic                    in_wlast,
    input  logic                    in_wvalid,
    output logic                    in_wready,
    output logic [ADDR_WIDTH-1:0]   req_addr,
    output logic [DATA_WIDTH-1:0]   req_data,
    output logic [DATA_WIDTH/8-1:0] req_strb,
    output logic                    req_last,
    output logic                    req_valid,
    input  logic                    req_ready,
    output logic [ID_WIDTH-1:0]     out_bid,
    output logic [1:0]              out_bresp,
    output logic                    out_bvalid,
    input  logic                    out_bready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int LOG2_BYTES = $clog2(STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_RESP
    } state_t;

    state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic                  err_q, err_d;
    logic                  wlast_err_q, wlast_err_d;

    logic                  aw_err;
    logic                  beat_done;
    logic                  last_beat;
    logic                  wlast_mismatch;
    logic                  resp_err;
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] next_addr;

    assign last_beat = (beat_cnt_q == len_q);
    assign resp_err  = err_q | wlast_err_q;

`ifdef WLAST_CHECK_EN
    assign wlast_mismatch = (in_wlast != last_beat);
`else
    logic unused_wlast;
    assign unused_wlast   = in_wlast;
    assign wlast_mismatch = 1'b0;
`endif

    // Bursts we cannot address correctly are accepted but drained and answered with SLVERR
    always_comb begin
        aw_err = 1'b0;
        if (in_awburst == 2'b11) begin
            aw_err = 1'b1;
        end
        if (int'(in_awsize) > LOG2_BYTES) begin
            aw_err = 1'b1;
        end
        if (in_awburst == 2'b10) begin
            if (!(in_awlen == 8'd1 || in_awlen == 8'd3 || in_awlen == 8'd7 || in_awlen == 8'd15)) begin
                aw_err = 1'b1;
            end
            if ((in_awaddr & ~({ADDR_WIDTH{1'b1}} << in_awsize)) != '0) begin
                aw_err = 1'b1;
            end
        end
    end

    // Address of the beat after the current one, per burst type
    always_comb begin
        step      = ONE << size_q;
        wrap_mask = ((ADDR_WIDTH'(len_q) + ONE) << size_q) - ONE;
        case (burst_q)
            2'b01:   next_addr = addr_q + step;
            2'b10:   next_addr = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
            default: next_addr = addr_q;
        endcase
    end

    // Next-state and handshake outputs; reset forces all valids/readies low
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        size_d      = size_q;
        burst_d     = burst_q;
        beat_cnt_d  = beat_cnt_q;
        err_d       = err_q;
        wlast_err_d = wlast_err_q;
        in_awready  = 1'b0;
        in_wready   = 1'b0;
        req_valid   = 1'b0;
        out_bvalid  = 1'b0;
        beat_done   = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_awready = 1'b1;
                if (in_awvalid) begin
                    id_d        = in_awid;
                    addr_d      = in_awaddr;
                    len_d       = in_awlen;
                    size_d      = in_awsize;
                    burst_d     = in_awburst;
                    beat_cnt_d  = 8'd0;
                    err_d       = aw_err;
                    wlast_err_d = 1'b0;
                    state_d     = S_DATA;
                end
            end
            S_DATA: begin
                if (err_q) begin
                    in_wready = 1'b1;
                    beat_done = in_wvalid;
                end else begin
                    in_wready = req_ready;
                    req_valid = in_wvalid;
                    beat_done = in_wvalid && req_ready;
                end
                if (beat_done) begin
                    addr_d = next_addr;
                    if (wlast_mismatch) begin
                        wlast_err_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d = S_RESP;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                end
            end
            S_RESP: begin
                out_bvalid = 1'b1;
                if (out_bready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (rst) begin
            in_awready = 1'b0;
            in_wready  = 1'b0;
            req_valid  = 1'b0;
            out_bvalid = 1'b0;
        end
    end

    assign req_addr  = addr_q;
    assign req_data  = in_wdata;
    assign req_strb  = in_wstrb;
    assign req_last  = (state_q == S_DATA) && last_beat;
    assign out_bid   = (state_q == S_RESP && !rst) ? id_q : '0;
    assign out_bresp = (state_q == S_RESP && !rst && resp_err) ? 2'b10 : 2'b00;

    // Burst context registers; reset abandons any burst in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            beat_cnt_q  <= '0;
            err_q       <= 1'b0;
            wlast_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            beat_cnt_q  <= beat_cnt_d;
            err_q       <= err_d;
            wlast_err_q <= wlast_err_d;
        end
    end

endmodule

// File: tb/tb_axi_write_beat_sequencer.sv
// tb/tb_axi_write_beat_sequencer.sv - directed self-checking bench for axi_write_beat_sequencer
module tb_axi_write_beat_sequencer;

    logic        clk;
    logic        rst;
    logic [31:0] in_awaddr;
    logic [3:0]  in_awid;
    logic [1:0]  in_awburst;
    logic [2:0]  in_awsize;
    logic [7:0]  in_awlen;
    logic        in_awvalid;
    logic        in_awready;
    logic [63:0] in_wdata;
    logic [7:0]  in_wstrb;
    logic        in_wlast;
    logic        in_wvalid;
    logic        in_wready;
    logic [31:0] req_addr;
    logic [63:0] req_data;
    logic [7:0]  req_strb;
    logic        req_last;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  out_bid;
    logic [1:0]  out_bresp;
    logic        out_bvalid;
    logic        out_bready;

    int total  = 0;
    int passed = 0;
    int hs_cnt = 0;

    axi_write_beat_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .in_awaddr  (in_awaddr),
        .in_awid    (in_awid),
        .in_awburst (in_awburst),
        .in_awsize  (in_awsize),
        .in_awlen   (in_awlen),
        .in_awvalid (in_awvalid),
        .in_awready (in_awready),
        .in_wdata   (in_wdata),
        .in_wstrb   (in_wstrb),
        .in_wlast   (in_wlast),
        .in_wvalid  (in_wvalid),
        .in_wready  (in_wready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_strb   (req_strb),
        .req_last   (req_last),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .out_bid    (out_bid),
        .out_bresp  (out_bresp),
        .out_bvalid (out_bvalid),
        .out_bready (out_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (req_valid && req_ready) hs_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic void chk(input string tag, input logic ok);
        total++;
        if (ok === 1'b1) passed++;
        else $error("FAIL %s", tag);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [31:0] a, input logic [3:0] id, input logic [1:0] b,
                           input logic [2:0] s, input logic [7:0] l);
        in_awaddr  = a;
        in_awid    = id;
        in_awburst = b;
        in_awsize  = s;
        in_awlen   = l;
        in_awvalid = 1'b1;
        #1;
        chk("aw_ready", in_awready === 1'b1);
        step();
        in_awvalid = 1'b0;
    endtask

    task automatic beat(input logic [31:0] ea, input logic el, input logic wl);
        logic [63:0] d;
        d         = {$urandom, $urandom};
        in_wdata  = d;
        in_wstrb  = 8'($urandom);
        in_wlast  = wl;
        in_wvalid = 1'b1;
        #1;
        chk("req_valid", req_valid === 1'b1);
        chk("w_ready", in_wready === 1'b1);
        chk("req_addr", req_addr === ea);
        chk("req_last", req_last === el);
        chk("req_data", req_data === d);
        step();
        in_wvalid = 1'b0;
    endtask

    task automatic drain();
        in_wvalid = 1'b1;
        req_ready = 1'b0;
        #1;
        chk("drain_wready", in_wready === 1'b1);
        chk("drain_req_valid", req_valid === 1'b0);
        step();
        in_wvalid = 1'b0;
        req_ready = 1'b1;
    endtask

    task automatic finish_b(input logic [3:0] id, input logic [1:0] resp);
        chk("bvalid", out_bvalid === 1'b1);
        chk("bid", out_bid === id);
        chk("bresp", out_bresp === resp);
        chk("resp_awready", in_awready === 1'b0);
        chk("resp_wready", in_wready === 1'b0);
        out_bready = 1'b1;
        step();
        out_bready = 1'b0;
        chk("bvalid_clear", out_bvalid === 1'b0);
        chk("idle_awready", in_awready === 1'b1);
    endtask

    initial begin
        rst        = 1'b1;
        in_awaddr  = '0;
        in_awid    = '0;
        in_awburst = '0;
        in_awsize  = '0;
        in_awlen   = '0;
        in_awvalid = 1'b1;
        in_wdata   = '0;
        in_wstrb   = '0;
        in_wlast   = 1'b0;
        in_wvalid  = 1'b1;
        req_ready  = 1'b1;
        out_bready = 1'b0;

        step();
        step();
        chk("rst_awready", in_awready === 1'b0);
        chk("rst_wready", in_wready === 1'b0);
        chk("rst_req_valid", req_valid === 1'b0);
        chk("rst_bvalid", out_bvalid === 1'b0);
        chk("rst_bid", out_bid === 4'h0);
        chk("rst_bresp", out_bresp === 2'b00);
        in_awvalid = 1'b0;
        in_wvalid  = 1'b0;
        rst        = 1'b0;
        step();
        chk("idle_awready0", in_awready === 1'b1);
        chk("idle_wready0", in_wready === 1'b0);

        send_aw(32'h1000, 4'h5, 2'b01, 3'd3, 8'd3);
        beat(32'h1000, 1'b0, 1'b0);
        beat(32'h1008, 1'b0, 1'b0);
        beat(32'h1010, 1'b0, 1'b0);
        beat(32'h1018, 1'b1, 1'b1);
        chk("t1_bvalid_first", out_bvalid === 1'b1);
        step();
        chk("t1_bvalid_hold", out_bvalid === 1'b1);
        chk("t1_bid_hold", out_bid === 4'h5);
        finish_b(4'h5, 2'b00);

        send_aw(32'h1018, 4'h2, 2'b10, 3'd3, 8'd3);
        beat(32'h1018, 1'b0, 1'b0);
        beat(32'h1000, 1'b0, 1'b0);
        beat(32'h1008, 1'b0, 1'b0);
        beat(32'h1010, 1'b1, 1'b1);
        finish_b(4'h2, 2'b00);

        hs_cnt = 0;
        send_aw(32'h2004, 4'h1, 2'b00, 3'd2, 8'd2);
        for (int i = 0; i < 3; i++) begin
            req_ready = 1'b0;
            in_wvalid = 1'b1;
            #1;
            chk("t3_stall_wready", in_wready === 1'b0);
            chk("t3_stall_valid", req_valid === 1'b1);
            chk("t3_stall_addr", req_addr === 32'h2004);
            step();
            req_ready = 1'b1;
            beat(32'h2004, (i == 2), (i == 2));
        end
        chk("t3_req_count", hs_cnt == 3);
        finish_b(4'h1, 2'b00);

        send_aw(32'hFFFF_FFF8, 4'h4, 2'b01, 3'd3, 8'd1);
        beat(32'hFFFF_FFF8, 1'b0, 1'b0);
        beat(32'h0000_0000, 1'b1, 1'b1);
        finish_b(4'h4, 2'b00);

        hs_cnt = 0;
        send_aw(32'h0, 4'hA, 2'b11, 3'd3, 8'd1);
        drain();
        drain();
        chk("t4_no_reqs", hs_cnt == 0);
        finish_b(4'hA, 2'b10);
        send_aw(32'h40, 4'hB, 2'b01, 3'd3, 8'd0);
        beat(32'h40, 1'b1, 1'b1);
        finish_b(4'hB, 2'b00);

        send_aw(32'h80, 4'hC, 2'b01, 3'd4, 8'd0);
        drain();
        finish_b(4'hC, 2'b10);
        send_aw(32'h0, 4'hD, 2'b10, 3'd3, 8'd2);
        drain();
        drain();
        drain();
        finish_b(4'hD, 2'b10);
        send_aw(32'h1004, 4'hE, 2'b10, 3'd3, 8'd1);
        drain();
        drain();
        finish_b(4'hE, 2'b10);

        send_aw(32'h1000, 4'h7, 2'b01, 3'd3, 8'd3);
        beat(32'h1000, 1'b0, 1'b0);
        in_wvalid = 1'b1;
        rst       = 1'b1;
        #1;
        chk("t5_rst_req_valid", req_valid === 1'b0);
        chk("t5_rst_wready", in_wready === 1'b0);
        chk("t5_rst_awready", in_awready === 1'b0);
        step();
        rst       = 1'b0;
        in_wvalid = 1'b0;
        #1;
        chk("t5_post_awready", in_awready === 1'b1);
        chk("t5_post_bvalid", out_bvalid === 1'b0);
        chk("t5_post_bid", out_bid === 4'h0);
        send_aw(32'h3000, 4'h3, 2'b01, 3'd3, 8'd1);
        beat(32'h3000, 1'b0, 1'b0);
        beat(32'h3008, 1'b1, 1'b1);
        finish_b(4'h3, 2'b00);

        send_aw(32'h500, 4'h9, 2'b01, 3'd3, 8'd3);
        beat(32'h500, 1'b0, 1'b0);
        beat(32'h508, 1'b0, 1'b1);
        beat(32'h510, 1'b0, 1'b0);
        beat(32'h518, 1'b1, 1'b1);
`ifdef WLAST_CHECK_EN
        finish_b(4'h9, 2'b10);
`else
        finish_b(4'h9, 2'b00);
`endif
        send_aw(32'h600, 4'h6, 2'b01, 3'd3, 8'd0);
        beat(32'h600, 1'b1, 1'b1);
        finish_b(4'h6, 2'b00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
